// File: rtl/prog_loader_if.sv
// Byte-stream and instruction-memory write signals of the program loader.
// Byte handshake: a byte moves on a rising CLK edge where BYTE_VALID and BYTE_READY are both 1.
interface prog_loader_if;
    logic        LOAD_REQ;
    logic [7:0]  BYTE_IN;
    logic        BYTE_VALID;
    logic        BYTE_READY;
    logic        IM_WE;
    logic [15:0] IM_WADDR;
    logic [25:0] IM_WDATA;
    logic        CPU_START;
    logic        DONE;
    logic        ERR;
    logic [2:0]  DBG_STATE;

    modport master (
        output LOAD_REQ, BYTE_IN, BYTE_VALID,
        input  BYTE_READY, IM_WE, IM_WADDR, IM_WDATA, CPU_START, DONE, ERR, DBG_STATE
    );

    modport slave (
        input  LOAD_REQ, BYTE_IN, BYTE_VALID,
        output BYTE_READY, IM_WE, IM_WADDR, IM_WDATA, CPU_START, DONE, ERR, DBG_STATE
    );
endinterface

// File: rtl/prog_loader.sv
// Serial program loader: header word count, 26-bit big-endian words written to
// instruction memory, XOR checksum gate before releasing the CPU.
module prog_loader #(
    parameter int MAX_WORDS = 1024
) (
    input  logic         CLK,
    input  logic         RST_N,
    prog_loader_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, HDR_HI, HDR_LO, WORD, WRITE, CHK, DONE_S, ERR_S
    } state_t;

    localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_n_hi;
    logic [15:0] r_count;
    logic [15:0] r_idx;
    logic [17:0] r_word;
    logic [1:0]  r_bcnt;
    logic [7:0]  r_xor;
    logic [15:0] r_waddr;
    logic [25:0] r_wdata;

    logic        w_ready;
    logic        w_acc;
    logic        w_restart;
    logic [15:0] w_n;
    logic [15:0] w_idx_inc;

    assign w_ready   = (r_state == HDR_HI) || (r_state == HDR_LO) ||
                       (r_state == WORD)   || (r_state == CHK);
    assign w_acc     = bus.BYTE_VALID && w_ready;
    assign w_restart = bus.LOAD_REQ &&
                       ((r_state == IDLE) || (r_state == DONE_S) || (r_state == ERR_S));
    assign w_n       = {r_n_hi, bus.BYTE_IN};
    assign w_idx_inc = r_idx + 16'd1;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE_S, ERR_S: if (bus.LOAD_REQ) w_next = HDR_HI;
            HDR_HI: if (w_acc) w_next = HDR_LO;
            HDR_LO: if (w_acc) begin
                if ({1'b0, w_n} > MAX_N) w_next = ERR_S;
                else if (w_n == 16'd0)   w_next = CHK;
                else                     w_next = WORD;
            end
            // Only bits [25:24] of a word may be set, so the leading byte must be 0..3.
            WORD: if (w_acc) begin
                if ((r_bcnt == 2'd0) && (bus.BYTE_IN[7:2] != 6'd0)) w_next = ERR_S;
                else if (r_bcnt == 2'd3)                             w_next = WRITE;
            end
            WRITE:  w_next = (w_idx_inc == r_count) ? CHK : WORD;
            CHK: if (w_acc) w_next = (bus.BYTE_IN == r_xor) ? DONE_S : ERR_S;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_n_hi  <= 8'd0;
            r_count <= 16'd0;
            r_idx   <= 16'd0;
            r_word  <= 18'd0;
            r_bcnt  <= 2'd0;
            r_xor   <= 8'd0;
            r_waddr <= 16'd0;
            r_wdata <= 26'd0;
        end else begin
            if (w_restart) begin
                r_idx  <= 16'd0;
                r_xor  <= 8'd0;
                r_bcnt <= 2'd0;
            end
            // The checksum byte itself is compared, not folded in.
            if (w_acc && (r_state != CHK)) r_xor <= r_xor ^ bus.BYTE_IN;
            if (w_acc && (r_state == HDR_HI)) r_n_hi <= bus.BYTE_IN;
            if (w_acc && (r_state == HDR_LO)) r_count <= w_n;
            if (w_acc && (r_state == WORD)) begin
                r_word <= {r_word[9:0], bus.BYTE_IN};
                r_bcnt <= r_bcnt + 2'd1;
                if (r_bcnt == 2'd3) begin
                    r_waddr <= r_idx;
                    r_wdata <= {r_word, bus.BYTE_IN};
                end
            end
            if (r_state == WRITE) r_idx <= w_idx_inc;
        end
    end

    assign bus.BYTE_READY = w_ready;
    assign bus.IM_WE      = (r_state == WRITE);
    assign bus.IM_WADDR   = r_waddr;
    assign bus.IM_WDATA   = r_wdata;
    assign bus.DONE       = (r_state == DONE_S);
    assign bus.ERR        = (r_state == ERR_S);
    assign bus.CPU_START  = (r_state == DONE_S);
    assign bus.DBG_STATE  = r_state;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: byte streams are parsed by a stream-level
// model into expected writes and outcome, then driven with random valid gaps.
module tb_prog_loader;

    localparam int MAXW = 1024;

    logic clk;
    logic rst_n;
    prog_loader_if bus();

    prog_loader #(.MAX_WORDS(MAXW)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    int          n_checks;
    int          n_fail;
    logic [41:0] exp_q[$];
    logic [7:0]  stim[$];
    logic [25:0] words[$];
    bit          exp_done;
    int          exp_term;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write monitor: every strobe must match the next write the model predicts.
    always @(negedge clk) begin
        if (rst_n && bus.IM_WE) begin
            if (exp_q.size() == 0) check("stray_we", {bus.IM_WADDR, bus.IM_WDATA}, 64'd0);
            else check("im_write", {bus.IM_WADDR, bus.IM_WDATA}, exp_q.pop_front());
        end
    end

    // Header count, four bytes per word, trailing XOR of all preceding bytes.
    task automatic mk_stream();
        logic [7:0]  acc;
        logic [31:0] w32;
        acc = 8'd0;
        stim.delete();
        stim.push_back(8'(words.size() >> 8));
        stim.push_back(8'(words.size()));
        foreach (words[i]) begin
            w32 = {6'd0, words[i]};
            for (int k = 3; k >= 0; k--) stim.push_back(w32[8*k +: 8]);
        end
        foreach (stim[i]) acc ^= stim[i];
        stim.push_back(acc);
    endtask

    // Reads the stream as the loader should: fills exp_q, exp_done and the
    // index of the byte after which the load must be finished.
    task automatic build_expect();
        int         n;
        int         p;
        logic [7:0] acc;
        exp_q.delete();
        exp_done = 1'b0;
        n   = 32'({stim[0], stim[1]});
        acc = stim[0] ^ stim[1];
        if (n > MAXW) begin
            exp_term = 1;
            return;
        end
        p = 2;
        for (int w = 0; w < n; w++) begin
            if (stim[p] > 8'h03) begin
                exp_term = p;
                return;
            end
            exp_q.push_back({16'(w), stim[p][1:0], stim[p+1], stim[p+2], stim[p+3]});
            acc ^= stim[p] ^ stim[p+1] ^ stim[p+2] ^ stim[p+3];
            p += 4;
        end
        exp_term = p;
        exp_done = (stim[p] == acc);
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap, output bit ok);
        int gap;
        gap = $urandom_range(max_gap, 0);
        ok  = 1'b0;
        repeat (gap) begin
            bus.BYTE_IN = 8'($urandom);
            @(negedge clk);
        end
        bus.BYTE_IN    = b;
        bus.BYTE_VALID = 1'b1;
        for (int t = 0; t < 20 && !ok; t++) begin
            if (bus.BYTE_READY) ok = 1'b1;
            @(negedge clk);
        end
        bus.BYTE_VALID = 1'b0;
        bus.BYTE_IN    = 8'($urandom);
    endtask

    task automatic run_load(input int max_gap, input bit mid_req);
        bit ok;
        build_expect();
        @(negedge clk);
        bus.LOAD_REQ = 1'b1;
        @(negedge clk);
        bus.LOAD_REQ = 1'b0;
        for (int i = 0; i <= exp_term; i++) begin
            bus.LOAD_REQ = mid_req && (i == 1);
            send_byte(stim[i], max_gap, ok);
            bus.LOAD_REQ = 1'b0;
            if (!ok) begin
                check("byte_accept", 64'(ok), 64'd1);
                return;
            end
        end
        check("done",        64'(bus.DONE),       64'(exp_done));
        check("err",         64'(bus.ERR),        64'(!exp_done));
        check("cpu_start",   64'(bus.CPU_START),  64'(exp_done));
        check("ready_off",   64'(bus.BYTE_READY), 64'd0);
        check("writes_left", 64'(exp_q.size()),   64'd0);
        repeat (2) @(negedge clk);
        check("hold", {bus.DONE, bus.ERR, bus.CPU_START}, {exp_done, !exp_done, exp_done});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         ok;
        int         n;
        int         mode;
        logic [7:0] hi;
        n_checks       = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        bus.LOAD_REQ   = 1'b0;
        bus.BYTE_IN    = 8'd0;
        bus.BYTE_VALID = 1'b0;
        #1;
        check("reset_outs", {bus.BYTE_READY, bus.IM_WE, bus.IM_WADDR, bus.IM_WDATA,
                             bus.CPU_START, bus.DONE, bus.ERR}, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_no_req", {bus.BYTE_READY, bus.DONE, bus.ERR}, 64'd0);

        // Two-word load, back-to-back bytes, correct checksum.
        words = '{26'h0000001, 26'h3FFFFFF};
        mk_stream();
        run_load(0, 1'b0);
        // Same stream closed with FE instead of the true XOR (FF).
        stim[stim.size()-1] = 8'hFE;
        run_load(0, 1'b0);
        // Leading word byte out of range.
        stim = '{8'h00, 8'h01, 8'h04, 8'h00, 8'h00, 8'h00};
        run_load(0, 1'b0);
        // Word count one above the limit.
        stim = '{8'h04, 8'h01};
        run_load(0, 1'b0);
        // Empty program, good and bad checksum.
        stim = '{8'h00, 8'h00, 8'h00};
        run_load(0, 1'b0);
        stim = '{8'h00, 8'h00, 8'h01};
        run_load(0, 1'b0);
        // Valid gaps on the two-word stream.
        words = '{26'h0000001, 26'h3FFFFFF};
        mk_stream();
        repeat (3) run_load(5, 1'b0);

        // Reset in the middle of a word, then a fresh three-word load.
        words.delete();
        repeat (3) words.push_back(26'($urandom));
        mk_stream();
        exp_q.delete();
        @(negedge clk);
        bus.LOAD_REQ = 1'b1;
        @(negedge clk);
        bus.LOAD_REQ = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(stim[i], 1, ok);
        #2 rst_n = 1'b0;
        #1;
        check("mid_reset_outs", {bus.BYTE_READY, bus.IM_WE, bus.IM_WADDR, bus.IM_WDATA,
                                 bus.CPU_START, bus.DONE, bus.ERR}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_rst", {bus.BYTE_READY, bus.DONE, bus.ERR}, 64'd0);
        run_load(2, 1'b0);

        // Largest accepted program.
        words.delete();
        repeat (MAXW) words.push_back(26'($urandom));
        mk_stream();
        run_load(0, 1'b0);

        // Random programs with random faults and stray LOAD_REQ pulses.
        repeat (30) begin
            n = $urandom_range(0, 4);
            words.delete();
            repeat (n) words.push_back(26'($urandom));
            mk_stream();
            mode = $urandom_range(0, 5);
            case (mode)
                3: stim[stim.size()-1] ^= 8'($urandom_range(1, 255));
                4: if (n > 0) stim[2 + 4 * $urandom_range(0, n - 1)] = 8'($urandom_range(4, 255));
                5: begin
                    hi = 8'($urandom_range(5, 255));
                    stim.delete();
                    stim.push_back(hi);
                    stim.push_back(8'($urandom));
                end
                default: ;
            endcase
            run_load($urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
